ysyx_23060042_lsu: RTL and testbench

//  Multi-cycle load/store unit directly downstream of the EXU.
//  - Takes the EXU's computed address, store data and access size; runs one access on a valid/ready memory bus.
//  - Returns a lane-aligned, sign/zero-extended load word as mrdata for writeback.
//  - Flags misaligned accesses and bus timeouts instead of hanging the core.

---
 rtl/ysyx_23060042_lsu.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_23060042_lsu.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060042_lsu.sv
// ysyx_23060042_lsu: multi-cycle load/store unit behind the EXU.
// One access per request on a valid/ready bus, with misalign and timeout abort.
module ysyx_23060042_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  Mren,
    input  logic        Mwen,
    input  logic        Munsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] mrdata,
    output logic        err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        wen_q, uns_q;
    logic [31:0] mrdata_q, mrdata_n;
    logic        err_q, err_n;

    logic        accept;
    logic        misalign;
    logic        tmo;
    logic [31:0] lane;
    logic [31:0] fmt;
    logic [3:0]  wmask;
    logic [31:0] wdata;

    assign accept   = (state == S_IDLE) && in_valid;
    assign misalign = ((Mren == 2'b10) && addr[0]) ||
                      ((Mren == 2'b11) && (addr[1:0] != 2'b00));
    // >= so a RESP entered on the last REQ cycle still aborts
    assign tmo      = (cnt >= TLAST);

    assign lane = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        fmt = lane;
        unique case (1'b1)
            size_q == 2'b01:
                fmt = {{24{~uns_q & lane[7]}}, lane[7:0]};
            size_q == 2'b10:
                fmt = {{16{~uns_q & lane[15]}}, lane[15:0]};
            default:
                fmt = lane;
        endcase
    end

    always_comb begin
        wmask = 4'hF;
        wdata = wdata_q;
        unique case (1'b1)
            size_q == 2'b01: begin
                wmask = 4'b0001 << addr_q[1:0];
                wdata = {4{wdata_q[7:0]}};
            end
            size_q == 2'b10: begin
                wmask = 4'b0011 << addr_q[1:0];
                wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                wmask = 4'hF;
                wdata = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mrdata_n = mrdata_q;
        err_n    = err_q;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    cnt_n = 8'd0;
                    if (Mren == 2'b00) begin
                        state_n  = S_DONE;
                        err_n    = 1'b0;
                        mrdata_n = 32'd0;
                    end else if (misalign) begin
                        state_n  = S_DONE;
                        err_n    = 1'b1;
                        mrdata_n = 32'd0;
                    end else begin
                        state_n = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                if (mem_ready) begin
                    state_n = S_RESP;
                end else if (tmo) begin
                    state_n  = S_DONE;
                    err_n    = 1'b1;
                    mrdata_n = 32'd0;
                end
            end
            S_RESP: begin
                cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                if (mem_rvalid) begin
                    state_n  = S_DONE;
                    err_n    = 1'b0;
                    mrdata_n = wen_q ? 32'd0 : fmt;
                end else if (tmo) begin
                    state_n  = S_DONE;
                    err_n    = 1'b1;
                    mrdata_n = 32'd0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n  = S_IDLE;
                    err_n    = 1'b0;
                    mrdata_n = 32'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            size_q   <= 2'b00;
            wen_q    <= 1'b0;
            uns_q    <= 1'b0;
            mrdata_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            mrdata_q <= mrdata_n;
            err_q    <= err_n;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= st_data;
                size_q  <= Mren;
                wen_q   <= Mwen;
                uns_q   <= Munsigned;
            end
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign mrdata    = mrdata_q;
    assign err       = err_q;
    assign mem_valid = (state == S_REQ);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wen   = (state == S_REQ) && wen_q;
    assign mem_wmask = ((state == S_REQ) && wen_q) ? wmask : 4'h0;
    assign mem_wdata = wdata;

endmodule

// File: tb/tb_ysyx_23060042_lsu.sv
// tb_ysyx_23060042_lsu: directed scenarios for the load/store unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ysyx_23060042_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [1:0]  Mren;
    logic        Mwen;
    logic        Munsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mrdata;
    logic        err;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    ysyx_23060042_lsu #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .addr(addr), .st_data(st_data), .Mren(Mren),
        .Mwen(Mwen), .Munsigned(Munsigned),
        .out_valid(out_valid), .out_ready(out_ready),
        .mrdata(mrdata), .err(err),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // zero-wait access; returns latency and bus view of the first REQ cycle
    task automatic xact(input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input logic [1:0] ren,
                        input logic wen, input logic uns,
                        output int lat, output logic [31:0] m,
                        output logic e, output logic vseen,
                        output logic [3:0] wm, output logic [31:0] wd);
        in_valid = 1'b1; addr = a; st_data = d;
        Mren = ren; Mwen = wen; Munsigned = uns;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 99; vseen = 1'b0; wm = 4'h0; wd = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            if (mem_valid && !vseen) begin
                vseen = 1'b1; wm = mem_wmask; wd = mem_wdata;
            end
            mem_rdata = rd;
            mem_rvalid = !in_ready && !mem_valid && !out_valid;
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        m = mrdata; e = err;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++;
            $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (err !== 1'b0 || mrdata !== 32'h0) begin failures++;
            $display("FAIL rst_result got=%b/%h exp=0/0", err, mrdata); end
        checks++; if (mem_valid !== 1'b0 || mem_wen !== 1'b0 || mem_wmask !== 4'h0) begin
            failures++;
            $display("FAIL rst_bus got=%b/%b/%h exp=0/0/0", mem_valid, mem_wen, mem_wmask); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_load;
        int lat; logic [31:0] m, wd; logic e, vs; logic [3:0] wm;
        xact(32'h80000004, 32'h0, 32'hDEADBEEF, 2'b11, 1'b0, 1'b0,
             lat, m, e, vs, wm, wd);
        checks++; if (lat !== 3) begin failures++;
            $display("FAIL word_lat got=%0d exp=3", lat); end
        checks++; if (m !== 32'hDEADBEEF || e !== 1'b0) begin failures++;
            $display("FAIL word_data got=%h/%b exp=deadbeef/0", m, e); end
        checks++; if (vs !== 1'b1 || wm !== 4'h0) begin failures++;
            $display("FAIL word_bus got=%b/%h exp=1/0", vs, wm); end
        checks++; if (mrdata !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL word_clear got=%h/%b/%b exp=0/0/1", mrdata, out_valid, in_ready); end
    endtask

    task automatic test_sub_load;
        int lat; logic [31:0] m, wd; logic e, vs; logic [3:0] wm;
        xact(32'h80000003, 32'h0, 32'h80FF7F01, 2'b01, 1'b0, 1'b0,
             lat, m, e, vs, wm, wd);
        checks++; if (m !== 32'hFFFFFF80 || e !== 1'b0) begin failures++;
            $display("FAIL lb_signed got=%h/%b exp=ffffff80/0", m, e); end
        xact(32'h80000003, 32'h0, 32'h80FF7F01, 2'b01, 1'b0, 1'b1,
             lat, m, e, vs, wm, wd);
        checks++; if (m !== 32'h00000080) begin failures++;
            $display("FAIL lbu got=%h exp=00000080", m); end
        xact(32'h80000001, 32'h0, 32'h80FF7F01, 2'b01, 1'b0, 1'b0,
             lat, m, e, vs, wm, wd);
        checks++; if (m !== 32'h0000007F) begin failures++;
            $display("FAIL lb_pos got=%h exp=0000007f", m); end
        xact(32'h80000002, 32'h0, 32'h80FF7F01, 2'b10, 1'b0, 1'b0,
             lat, m, e, vs, wm, wd);
        checks++; if (m !== 32'hFFFF80FF) begin failures++;
            $display("FAIL lh_signed got=%h exp=ffff80ff", m); end
        xact(32'h80000000, 32'h0, 32'h80FF7F01, 2'b10, 1'b0, 1'b1,
             lat, m, e, vs, wm, wd);
        checks++; if (m !== 32'h00007F01) begin failures++;
            $display("FAIL lhu got=%h exp=00007f01", m); end
    endtask

    task automatic test_half_store;
        int vc; logic stable;
        mem_ready = 1'b0;
        in_valid = 1'b1; addr = 32'h80000002; st_data = 32'h1234ABCD;
        Mren = 2'b10; Mwen = 1'b1; Munsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        vc = 0; stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!mem_valid) break;
            vc++;
            if (mem_wmask !== 4'b1100 || mem_wdata !== 32'hABCDABCD ||
                mem_addr !== 32'h80000000 || mem_wen !== 1'b1)
                stable = 1'b0;
            mem_ready = (vc >= 4);
            @(negedge clk);
        end
        checks++; if (vc !== 4) begin failures++;
            $display("FAIL sh_valid_cycles got=%0d exp=4", vc); end
        checks++; if (stable !== 1'b1) begin failures++;
            $display("FAIL sh_bus_fields got=%h/%h/%h exp=c/abcdabcd/80000000",
                     mem_wmask, mem_wdata, mem_addr); end
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++; if (out_valid !== 1'b1 || mrdata !== 32'h0 || err !== 1'b0) begin
            failures++;
            $display("FAIL sh_result got=%b/%h/%b exp=1/0/0", out_valid, mrdata, err); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_stores;
        int lat; logic [31:0] m, wd; logic e, vs; logic [3:0] wm;
        xact(32'h80000001, 32'h000000A5, 32'h0, 2'b01, 1'b1, 1'b0,
             lat, m, e, vs, wm, wd);
        checks++; if (wm !== 4'b0010 || wd !== 32'hA5A5A5A5) begin failures++;
            $display("FAIL sb_bus got=%h/%h exp=2/a5a5a5a5", wm, wd); end
        xact(32'h80000010, 32'hCAFEBABE, 32'h11111111, 2'b11, 1'b1, 1'b0,
             lat, m, e, vs, wm, wd);
        checks++; if (wm !== 4'hF || wd !== 32'hCAFEBABE) begin failures++;
            $display("FAIL sw_bus got=%h/%h exp=f/cafebabe", wm, wd); end
        checks++; if (lat !== 3 || m !== 32'h0 || e !== 1'b0) begin failures++;
            $display("FAIL sw_result got=%0d/%h/%b exp=3/0/0", lat, m, e); end
    endtask

    task automatic test_misaligned;
        int lat; logic [31:0] m, wd; logic e, vs; logic [3:0] wm;
        xact(32'h80000001, 32'h0, 32'h12345678, 2'b11, 1'b0, 1'b0,
             lat, m, e, vs, wm, wd);
        checks++; if (lat !== 1 || e !== 1'b1 || m !== 32'h0 || vs !== 1'b0) begin
            failures++;
            $display("FAIL mis_word got=%0d/%b/%h/%b exp=1/1/0/0", lat, e, m, vs); end
        xact(32'h80000003, 32'h0, 32'h12345678, 2'b10, 1'b1, 1'b0,
             lat, m, e, vs, wm, wd);
        checks++; if (lat !== 1 || e !== 1'b1 || vs !== 1'b0) begin failures++;
            $display("FAIL mis_half got=%0d/%b/%b exp=1/1/0", lat, e, vs); end
        xact(32'h80000003, 32'h0, 32'h12345678, 2'b00, 1'b0, 1'b0,
             lat, m, e, vs, wm, wd);
        checks++; if (lat !== 1 || e !== 1'b0 || m !== 32'h0 || vs !== 1'b0) begin
            failures++;
            $display("FAIL none_req got=%0d/%b/%h/%b exp=1/0/0/0", lat, e, m, vs); end
    endtask

    task automatic test_timeout;
        int vc;
        mem_ready = 1'b0;
        in_valid = 1'b1; addr = 32'h80000000; Mren = 2'b11;
        Mwen = 1'b0; Munsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        vc = 0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) break;
            if (mem_valid) vc++;
            @(negedge clk);
        end
        checks++; if (vc !== 8) begin failures++;
            $display("FAIL tmo_cycles got=%0d exp=8", vc); end
        checks++; if (out_valid !== 1'b1 || err !== 1'b1 || mrdata !== 32'h0) begin
            failures++;
            $display("FAIL tmo_result got=%b/%b/%h exp=1/1/0", out_valid, err, mrdata); end
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++; if (out_valid !== 1'b1 || err !== 1'b1 || mrdata !== 32'h0) begin
            failures++;
            $display("FAIL tmo_late_done got=%b/%b/%h exp=1/1/0", out_valid, err, mrdata); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL tmo_late_idle got=%b/%b/%b exp=0/1/0", out_valid, in_ready, mem_valid); end
        mem_ready = 1'b1;
    endtask

    task automatic test_done_stall;
        in_valid = 1'b1; addr = 32'h80000008; Mren = 2'b11;
        Mwen = 1'b0; Munsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        addr = 32'h80000020; Mren = 2'b01;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || mrdata !== 32'hCAFEF00D ||
                err !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL done_hold%0d got=%b/%h/%b/%b exp=1/cafef00d/0/0",
                         k, out_valid, mrdata, err, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL done_release got=%b/%b/%b exp=0/1/0", out_valid, in_ready, mem_valid); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] m, wd; logic e, vs; logic [3:0] wm;
        mem_ready = 1'b0;
        in_valid = 1'b1; addr = 32'h80000004; Mren = 2'b11;
        Mwen = 1'b0; Munsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (mem_valid !== 1'b1) begin failures++;
            $display("FAIL mid_req got=%b exp=1", mem_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got=%b/%b/%b exp=0/0/1", mem_valid, out_valid, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
            $display("FAIL post_reset got=%b/%b exp=0/1", out_valid, in_ready); end
        xact(32'h8000000C, 32'h0, 32'h00C0FFEE, 2'b11, 1'b0, 1'b0,
             lat, m, e, vs, wm, wd);
        checks++; if (lat !== 3 || m !== 32'h00C0FFEE || e !== 1'b0) begin failures++;
            $display("FAIL post_reset_load got=%0d/%h/%b exp=3/00c0ffee/0", lat, m, e); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; addr = 32'h0; st_data = 32'h0;
        Mren = 2'b00; Mwen = 1'b0; Munsigned = 1'b0; out_ready = 1'b0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset;
        test_word_load;
        test_sub_load;
        test_half_store;
        test_stores;
        test_misaligned;
        test_timeout;
        test_done_stall;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
